// File: rtl/cache_pkg.sv
// Shared types and geometry for the 4-way, 16-set, 32-byte-line write-back cache.
package cache_pkg;

  localparam int unsigned NUM_WAYS  = 4;
  localparam int unsigned NUM_SETS  = 16;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned TAG_W     = 23;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned OFF_W     = 5;
  localparam int unsigned WAY_W     = 2;
  localparam int unsigned WORD_W    = 3;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [OFF_W-1:0]  off_t;
  typedef logic [WAY_W-1:0]  way_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    tag_t tag;
    idx_t idx;
    off_t off;
  } addr_t;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate
  } state_e;

endpackage

// File: rtl/cache_plru.sv
// Per-set victim selection. CACHE_PLRU_EN selects a 3-bit tree pseudo-LRU updated on hits;
// otherwise a 2-bit round-robin counter per set advances on every allocate.
module cache_plru #(
  parameter int unsigned NUM_SETS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  cache_pkg::idx_t idx,
  input  logic            hit,
  input  cache_pkg::way_t hit_way,
  input  logic            alloc,
  output cache_pkg::way_t victim
);
  import cache_pkg::*;

`ifdef CACHE_PLRU_EN
  // bit0: 1 -> right half is older; bit1 picks within ways 0/1; bit2 within ways 2/3
  logic [2:0] tree_q [NUM_SETS];
  logic       unused_alloc;

  assign unused_alloc = alloc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
    end else if (hit) begin
      if (!hit_way[1]) begin
        tree_q[idx][0] <= 1'b1;
        tree_q[idx][1] <= ~hit_way[0];
      end else begin
        tree_q[idx][0] <= 1'b0;
        tree_q[idx][2] <= ~hit_way[0];
      end
    end
  end

  always_comb begin
    victim = tree_q[idx][0] ? {1'b1, tree_q[idx][2]} : {1'b0, tree_q[idx][1]};
  end
`else
  logic [1:0] rr_q [NUM_SETS];
  logic       unused_hit;

  assign unused_hit = ^{hit, hit_way};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else if (alloc) begin
      rr_q[idx] <= rr_q[idx] + 2'd1;
    end
  end

  assign victim = rr_q[idx];
`endif

endmodule

// File: rtl/cache.sv
// 4-way set-associative write-back, write-allocate cache with a single-line memory port.
// Replacement policy: define CACHE_PLRU_EN for tree pseudo-LRU, else round-robin.
module cache #(
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned NUM_SETS  = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ufp_addr,
  input  logic [3:0]           ufp_rmask,
  input  logic [3:0]           ufp_wmask,
  output logic [31:0]          ufp_rdata,
  input  logic [31:0]          ufp_wdata,
  output logic                 ufp_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic                 dfp_resp
);
  import cache_pkg::*;

  state_e state_q, state_d;

  addr_t       in_addr;
  tag_t        req_tag_q;
  idx_t        req_idx_q;
  word_t       req_word_q;
  logic [3:0]  req_wmask_q;
  logic [31:0] req_wdata_q;
  logic        unused_addr;

  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
  tag_t                 tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic                 req_start, is_write;
  logic                 hit, has_invalid, miss;
  logic                 upd_hit, wb_done, alloc_done;
  way_t                 hit_way, inv_way, pick_way, plru_victim, victim_q;
  logic [LINE_BITS-1:0] hit_line, hit_line_wr;
  logic [31:0]          hit_word, merged_word;

  assign in_addr     = addr_t'(ufp_addr);
  assign unused_addr = ^ufp_addr[1:0];
  assign req_start   = (state_q == StIdle) && ((|ufp_rmask) || (|ufp_wmask));
  assign is_write    = |req_wmask_q;

  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
    end
    // Scan downwards so the lowest-numbered invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx_q][w]) begin
        has_invalid = 1'b1;
        inv_way     = way_t'(w);
      end
    end
    pick_way = has_invalid ? inv_way : plru_victim;
  end

  always_comb begin
    hit_line = data_q[req_idx_q][hit_way];
    hit_word = hit_line[{req_word_q, 5'b0} +: 32];
    for (int b = 0; b < 4; b++) begin
      merged_word[8*b +: 8] = req_wmask_q[b] ? req_wdata_q[8*b +: 8] : hit_word[8*b +: 8];
    end
    hit_line_wr = hit_line;
    hit_line_wr[{req_word_q, 5'b0} +: 32] = merged_word;
  end

  always_comb begin
    state_d    = state_q;
    ufp_resp   = 1'b0;
    ufp_rdata  = '0;
    dfp_read   = 1'b0;
    dfp_write  = 1'b0;
    dfp_addr   = '0;
    dfp_wdata  = '0;
    upd_hit    = 1'b0;
    miss       = 1'b0;
    wb_done    = 1'b0;
    alloc_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_start) state_d = StCompare;
      end
      StCompare: begin
        if (hit) begin
          // Combined read/write returns the word as it was before the merge.
          ufp_resp  = 1'b1;
          ufp_rdata = hit_word;
          upd_hit   = 1'b1;
          state_d   = StIdle;
        end else begin
          miss    = 1'b1;
          state_d = (valid_q[req_idx_q][pick_way] && dirty_q[req_idx_q][pick_way]) ?
                    StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        dfp_write = 1'b1;
        dfp_addr  = {tag_q[req_idx_q][victim_q], req_idx_q, 5'b0};
        dfp_wdata = data_q[req_idx_q][victim_q];
        if (dfp_resp) begin
          wb_done = 1'b1;
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        dfp_read = 1'b1;
        dfp_addr = {req_tag_q, req_idx_q, 5'b0};
        if (dfp_resp) begin
          alloc_done = 1'b1;
          state_d    = StCompare;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      req_wmask_q <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (req_start) begin
        req_tag_q   <= in_addr.tag;
        req_idx_q   <= in_addr.idx;
        req_word_q  <= in_addr.off[4:2];
        req_wmask_q <= ufp_wmask;
        req_wdata_q <= ufp_wdata;
      end
      if (miss) victim_q <= pick_way;
      if (upd_hit && is_write) dirty_q[req_idx_q][hit_way] <= 1'b1;
      if (wb_done) dirty_q[req_idx_q][victim_q] <= 1'b0;
      if (alloc_done) begin
        valid_q[req_idx_q][victim_q] <= 1'b1;
        dirty_q[req_idx_q][victim_q] <= 1'b0;
      end
    end
  end

  // Tags and line data are only meaningful under valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alloc_done) begin
      data_q[req_idx_q][victim_q] <= dfp_rdata;
      tag_q[req_idx_q][victim_q]  <= req_tag_q;
    end else if (upd_hit && is_write) begin
      data_q[req_idx_q][hit_way] <= hit_line_wr;
    end
  end

  cache_plru #(
    .NUM_SETS(NUM_SETS)
  ) u_plru (
    .clk    (clk),
    .rst    (rst),
    .idx    (req_idx_q),
    .hit    (upd_hit),
    .hit_way(hit_way),
    .alloc  (alloc_done),
    .victim (plru_victim)
  );

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for cache: directed requests push expected CPU and memory transactions;
// independent monitors pop and compare them as the DUT presents them.
module tb_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  ufp_addr = '0;
  logic [3:0]   ufp_rmask = '0;
  logic [3:0]   ufp_wmask = '0;
  logic [31:0]  ufp_rdata;
  logic [31:0]  ufp_wdata = '0;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_rdata = '0;
  logic [255:0] dfp_wdata;
  logic         dfp_resp = 1'b0;

  always #5 clk = ~clk;

  cache dut (
    .clk      (clk),
    .rst      (rst),
    .ufp_addr (ufp_addr),
    .ufp_rmask(ufp_rmask),
    .ufp_wmask(ufp_wmask),
    .ufp_rdata(ufp_rdata),
    .ufp_wdata(ufp_wdata),
    .ufp_resp (ufp_resp),
    .dfp_addr (dfp_addr),
    .dfp_read (dfp_read),
    .dfp_write(dfp_write),
    .dfp_rdata(dfp_rdata),
    .dfp_wdata(dfp_wdata),
    .dfp_resp (dfp_resp)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int          lat;
  } ufp_exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] w0;
    logic [31:0] w1;
  } dfp_exp_t;

  ufp_exp_t    ufp_q[$];
  dfp_exp_t    dfp_q[$];
  logic [31:0] mem [int unsigned];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hBEEF};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CPU-side monitor.
  always @(negedge clk) begin : ufp_mon
    ufp_exp_t e;
    if (rst) begin
      if (ufp_resp) begin
        n_cmp++;
        if (ufp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ufp_resp: rdata %h, none expected (t=%0t)", ufp_rdata, $time);
        end else begin
          e = ufp_q.pop_front();
          if (e.chk) check("ufp_rdata", ufp_rdata, e.rdata);
          if (e.lat >= 0) check("hit_latency", cyc - req_cyc, e.lat);
        end
      end else begin
        check("rdata_zero_without_resp", ufp_rdata, 32'h0);
      end
      check("dfp_rw_exclusive", {31'b0, dfp_read & dfp_write}, 32'h0);
    end
  end

  // Memory model and memory-side monitor.
  always begin : mem_model
    dfp_exp_t    d;
    bit          wr;
    bit          ok;
    logic [31:0] a;
    @(negedge clk);
    if (rst && (dfp_read || dfp_write)) begin
      wr = dfp_write;
      a  = dfp_addr;
      n_cmp++;
      if (dfp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_dfp: write=%0d addr %h, none expected", wr, a);
      end else begin
        d = dfp_q.pop_front();
        check("dfp_is_write", {31'b0, wr}, {31'b0, d.wr});
        check("dfp_addr", a, d.addr);
        if (d.wr) begin
          check("wb_word0", dfp_wdata[31:0], d.w0);
          check("wb_word1", dfp_wdata[63:32], d.w1);
        end
      end
      ok = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (!rst) ok = 1'b0;
      end
      if (ok) begin
        for (int w = 0; w < 8; w++) begin
          if (wr) mem[a + 32'(4 * w)] = dfp_wdata[32*w +: 32];
          else dfp_rdata[32*w +: 32] = mem_rd(a + 32'(4 * w));
        end
        dfp_resp = 1'b1;
        @(negedge clk);
        dfp_resp = 1'b0;
      end
    end
  end

  task automatic push_rd(input logic [31:0] a);
    dfp_q.push_back('{wr: 1'b0, addr: a, w0: 32'h0, w1: 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
    dfp_q.push_back('{wr: 1'b1, addr: a, w0: w0, w1: w1});
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    ufp_addr  = a;
    ufp_rmask = rm;
    ufp_wmask = wm;
    ufp_wdata = wd;
    req_cyc   = cyc;
  endtask

  task automatic wait_resp(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = ufp_resp;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no ufp_resp within 200 cycles", name);
    end
    @(posedge clk);
    #1;
    ufp_rmask = '0;
    ufp_wmask = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                     input logic [31:0] wd, input bit chk, input logic [31:0] exp,
                     input int lat, input string name);
    ufp_q.push_back('{rdata: exp, chk: chk, lat: lat});
    issue(a, rm, wm, wd);
    wait_resp(name);
  endtask

  initial begin : stim
    bit seen;
    mem[32'h0] = 32'h1111_1111;
    mem[32'h4] = 32'h2222_2222;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ufp_resp", {31'b0, ufp_resp}, 32'h0);
    check("rst_ufp_rdata", ufp_rdata, 32'h0);
    check("rst_dfp_rw", {30'b0, dfp_read, dfp_write}, 32'h0);
    check("rst_dfp_addr", dfp_addr, 32'h0);
    check("rst_dfp_wdata", {31'b0, |dfp_wdata}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    push_rd(32'h0);
    req(32'h0, 4'hF, 4'h0, 32'h0, 1'b1, 32'h1111_1111, -1, "cold_read_0");
    req(32'h4, 4'hF, 4'h0, 32'h0, 1'b1, 32'h2222_2222, 1, "hit_read_4");
    req(32'h0, 4'h0, 4'b0011, 32'hAAAA_BBBB, 1'b0, 32'h0, 1, "write_hit_0");
    req(32'h0, 4'hF, 4'h0, 32'h0, 1'b1, 32'h1111_BBBB, 1, "read_merged_0");
    req(32'h4, 4'hF, 4'b1100, 32'hCCCC_0000, 1'b1, 32'h2222_2222, 1, "rw_both_4");
    req(32'h4, 4'hF, 4'h0, 32'h0, 1'b1, 32'hCCCC_2222, 1, "read_merged_4");

    push_rd(32'h200);
    req(32'h200, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0200_BEEF, -1, "fill_200");
    push_rd(32'h400);
    req(32'h400, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0400_BEEF, -1, "fill_400");
    push_rd(32'h600);
    req(32'h600, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0600_BEEF, -1, "fill_600");
    push_wr(32'h0, 32'h1111_BBBB, 32'hCCCC_2222);
    push_rd(32'h800);
    req(32'h800, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0800_BEEF, -1, "evict_800");
    req(32'h804, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0804_BEEF, 1, "hit_804");

    // Reset in the middle of a line fill.
    push_rd(32'h20);
    issue(32'h20, 4'hF, 4'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = dfp_read;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL abort_fill_start: dfp_read never rose within 50 cycles");
    end
    #2;
    rst = 1'b0;
    #1;
    check("abort_dfp_read", {31'b0, dfp_read}, 32'h0);
    check("abort_dfp_addr", dfp_addr, 32'h0);
    ufp_rmask = '0;
    ufp_wmask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    push_rd(32'h0);
    req(32'h0, 4'hF, 4'h0, 32'h0, 1'b1, 32'h1111_BBBB, -1, "post_reset_miss_0");
    req(32'h4, 4'hF, 4'h0, 32'h0, 1'b1, 32'hCCCC_2222, 1, "post_reset_hit_4");

    repeat (10) @(negedge clk);
    n_cmp++;
    if (ufp_q.size() != 0 || dfp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: ufp %0d dfp %0d, expected 0 and 0",
               ufp_q.size(), dfp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4: ways per set (fixed at 4 with 2-bit way index).
REQ-002 SHALL have parameter NUM_SETS, default 16: sets, index = ufp_addr[8:5].
REQ-003 SHALL have parameter LINE_BITS, default 256: line size, 32 bytes, offset = ufp_addr[4:0].
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ufp_addr, input, 32: CPU byte address; bits [1:0] ignored.
REQ-007 SHALL have port ufp_rmask, input, 4: byte read mask; nonzero means read request.
REQ-008 SHALL have port ufp_wmask, input, 4: byte write mask; nonzero means write request.
REQ-009 SHALL have port ufp_rdata, output, 32: read word.
REQ-010 SHALL have port ufp_wdata, input, 32: write word.
REQ-011 SHALL have port ufp_resp, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port dfp_addr, output, 32: memory line address, bits [4:0] = 0.
REQ-013 SHALL have port dfp_read, output, 1: line read request.
REQ-014 SHALL have port dfp_write, output, 1: line write request.
REQ-015 SHALL have port dfp_rdata, input, 256: returned line.
REQ-016 SHALL have port dfp_wdata, output, 256: writeback line.
REQ-017 SHALL have port dfp_resp, input, 1: memory completion pulse.

Function
REQ-018 SHALL be 4-way set-associative, write-back, write-allocate; tag = ufp_addr[31:9] (23 bits); per way/set: valid, dirty, tag, 256-bit data.
REQ-019 SHALL use FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-020 IDLE: request when (ufp_rmask|ufp_wmask)!=0 -> latch addr/masks/wdata, go COMPARE; else stay.
REQ-021 COMPARE hit (valid && tag match): ufp_resp=1 this cycle, go IDLE; hit latency = 1 cycle after request cycle.
REQ-022 Read hit: ufp_rdata = line word addr[4:2], full 32 bits regardless of rmask; ufp_rdata is 0 when ufp_resp=0.
REQ-023 Write hit: merge ufp_wdata bytes per wmask into word addr[4:2], set dirty, ufp_resp=1.
REQ-024 Both masks nonzero: SHALL be treated as write; ufp_rdata returns the pre-write word.
REQ-025 COMPARE miss: choose victim (invalid way lowest index first, else replacement policy); victim valid && dirty -> WRITEBACK, else -> ALLOCATE.
REQ-026 WRITEBACK: dfp_write=1, dfp_addr={victim tag, index, 5'b0}, dfp_wdata=victim line, held until dfp_resp; then clear dirty, go ALLOCATE.
REQ-027 ALLOCATE: dfp_read=1, dfp_addr={req tag, index, 5'b0}, held until dfp_resp; then write dfp_rdata into victim, valid=1, dirty=0, tag set, go COMPARE (hit follows).
REQ-028 dfp_read and dfp_write SHALL never be asserted together; dfp_resp outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-029 Replacement state SHALL update on every hit (the ufp_resp cycle), marking the accessed way most recently used.
REQ-030 Requester holds inputs stable until ufp_resp; a new request may be presented in the cycle after ufp_resp.

Reset
REQ-031 While rst=0: state IDLE; all valid, dirty, replacement bits 0; ufp_resp, ufp_rdata, dfp_read, dfp_write, dfp_addr, dfp_wdata = 0.
REQ-032 Reset asserted mid-miss SHALL abort the transaction immediately (dfp_read/dfp_write drop asynchronously); line data contents need not be cleared.

Configuration
REQ-033 With CACHE_PLRU_EN defined: victim = 3-bit tree pseudo-LRU per set; without it: victim = per-set 2-bit round-robin counter, incremented on each allocate.

Structure
REQ-034 Package cache_pkg SHALL hold the state enum, NUM_WAYS, NUM_SETS, LINE_BITS, TAG_W=23, IDX_W=4, OFF_W=5 and address-field typedefs.
REQ-035 Replacement logic SHALL be a sub-module cache_plru (victim output, hit-way update input, per set).

Verification
REQ-036 After reset, read 0x00000000 rmask 4'hF (mem word 0x11111111) -> dfp_read, dfp_addr 0x00000000, then ufp_resp with rdata 0x11111111.
REQ-037 Repeat read 0x00000004 -> ufp_resp 1 cycle after request, no dfp_read, rdata equals mem word 0x4.
REQ-038 Write 0x00000000 wmask 4'b0011 wdata 0xAAAABBBB, then read -> rdata 0x1111BBBB, no dfp activity.
REQ-039 Reads 0x200, 0x400, 0x600, 0x800 (same set 0) after dirty 0x0 -> fifth miss triggers dfp_write dfp_addr 0x00000000 containing 0x1111BBBB, then dfp_read 0x800.
REQ-040 Assert rst during ALLOCATE -> dfp_read 0 immediately; subsequent read of 0x0 misses again.
